// File: rtl/shiftreg_pkg.sv
// Shared definitions for the SPI shift datapath, the SPI slave FSM and the
// multiplier blocks: FSM state encoding and bit-order constants.
package shiftreg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic MSB_FIRST = 1'b0;
   localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/shiftreg_bitcounter.sv
// Frame bit counter for spi_frame_shiftreg.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   clr          : synchronous clear to zero (priority over en)
//   en           : count one received bit
//   len          : latched frame length (1..WIDTH)
//   last         : high when the next counted bit completes the frame
module shiftreg_bitcounter
   import shiftreg_pkg::*;
#(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] len,
   output logic             last
);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_inc;

   assign w_count_inc = r_count + CNT_W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= w_count_inc;
      end
   end

   assign last = (w_count_inc == len);

endmodule

// File: rtl/spi_frame_shiftreg.sv
// Serial/parallel shift engine under the SPI slave FSM. Loads a transmit word,
// shifts receive bits in on sclk_pos and launches transmit bits on sclk_neg,
// with per-frame length and bit order, and pulses done at frame end.
// Ports:
//   clk, reset_n          : system clock, asynchronous active-low reset
//   sclk_pos / sclk_neg   : SPI sample / launch edge strobes
//   load, lsb_first,
//   frame_len, parallel_in: frame start and its latched attributes
//   hold                  : freeze (strobes dropped while high)
//   abort                 : synchronous frame cancel
//   serial_in             : receive bit
//   parallel_out          : shift register contents
//   serial_out            : registered transmit bit
//   busy, done            : in-frame flag, one-cycle completion pulse
module spi_frame_shiftreg
   import shiftreg_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sclk_pos,
   input  logic             sclk_neg,
   input  logic             load,
   input  logic             lsb_first,
   input  logic [CNT_W-1:0] frame_len,
   input  logic             hold,
   input  logic             abort,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             serial_in,
   output logic [WIDTH-1:0] parallel_out,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_mem;
   logic             r_sout;
   logic             r_dir;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] w_len_eff;
   logic             w_load;
   logic             w_shift;
   logic             w_launch;
   logic             w_last;

   // Out-of-range lengths (0 or above WIDTH) mean a full-width frame.
   assign w_len_eff = ((frame_len == '0) || (frame_len > CNT_W'(WIDTH)))
                      ? CNT_W'(WIDTH) : frame_len;

   // abort outranks everything; sclk_pos outranks sclk_neg in the same cycle.
   assign w_load   = (r_state == ST_IDLE)  && load && !abort;
   assign w_shift  = (r_state == ST_SHIFT) && sclk_pos && !hold && !abort;
   assign w_launch = (r_state == ST_SHIFT) && sclk_neg && !sclk_pos && !hold && !abort;

   shiftreg_bitcounter #(
      .CNT_W (CNT_W)
   ) u_bitcounter (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (abort || w_load),
      .en      (w_shift),
      .len     (r_len),
      .last    (w_last)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      if (abort) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (load) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_shift && w_last) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         ST_SHIFT: busy = 1'b1;
         ST_DONE:  done = 1'b1;
         default:  ;
      endcase
   end

   // Datapath: memory, transmit bit and latched frame attributes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem  <= '0;
         r_sout <= 1'b0;
         r_dir  <= MSB_FIRST;
         r_len  <= CNT_W'(WIDTH);
      end else if (w_load) begin
         r_mem  <= parallel_in;
         r_dir  <= lsb_first;
         r_len  <= w_len_eff;
         r_sout <= (lsb_first == LSB_FIRST) ? parallel_in[0] : parallel_in[WIDTH-1];
      end else if (w_shift) begin
         if (r_dir == LSB_FIRST) begin
            r_mem <= {serial_in, r_mem[WIDTH-1:1]};
         end else begin
            r_mem <= {r_mem[WIDTH-2:0], serial_in};
         end
      end else if (w_launch) begin
         r_sout <= (r_dir == LSB_FIRST) ? r_mem[0] : r_mem[WIDTH-1];
      end
   end

   assign parallel_out = r_mem;
   assign serial_out   = r_sout;

endmodule

// File: tb/tb_spi_frame_shiftreg.sv
module tb_spi_frame_shiftreg;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          reset_n;
   logic          sclk_pos, sclk_neg, load, lsb_first, hold, abort, serial_in;
   logic [CW-1:0] frame_len;
   logic [W-1:0]  parallel_in;
   logic [W-1:0]  parallel_out;
   logic          serial_out, busy, done;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;

   // Reference model: frame-level view (phase 0 idle, 1 shifting, 2 done)
   int           m_phase;
   int           m_k;
   int           m_len;
   bit           m_dir;
   logic [W-1:0] m_tx;
   logic [W-1:0] m_mem;
   logic         m_sout;
   bit           rxq [W];

   always #5 clk = ~clk;

   spi_frame_shiftreg #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sclk_pos     (sclk_pos),
      .sclk_neg     (sclk_neg),
      .load         (load),
      .lsb_first    (lsb_first),
      .frame_len    (frame_len),
      .hold         (hold),
      .abort        (abort),
      .parallel_in  (parallel_in),
      .serial_in    (serial_in),
      .parallel_out (parallel_out),
      .serial_out   (serial_out),
      .busy         (busy),
      .done         (done)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Memory after k received bits: the loaded word moved k places toward the
   // far end, with the received bits occupying the vacated positions.
   function automatic logic [W-1:0] model_mem();
      logic [W-1:0] acc;
      acc = '0;
      if (!m_dir) begin
         for (int j = 0; j < m_k; j++) acc = acc * 2 + W'(rxq[j]);
         return (m_tx << m_k) | acc;
      end else begin
         for (int j = 0; j < m_k; j++) acc = acc | (W'(rxq[j]) << j);
         return (m_tx >> m_k) | (acc << (W - m_k));
      end
   endfunction

   task automatic model_reset();
      m_phase = 0; m_k = 0; m_len = W; m_dir = 0;
      m_tx = '0; m_mem = '0; m_sout = 1'b0;
   endtask

   task automatic tick();
      if (!reset_n) begin
         model_reset();
      end else if (abort) begin
         m_phase = 0;
      end else begin
         case (m_phase)
            0: if (load) begin
                  m_tx    = parallel_in;
                  m_dir   = lsb_first;
                  m_len   = (frame_len == 0 || frame_len > W) ? W : int'(frame_len);
                  m_k     = 0;
                  m_mem   = parallel_in;
                  m_sout  = lsb_first ? parallel_in[0] : parallel_in[W-1];
                  m_phase = 1;
               end
            1: if (!hold) begin
                  if (sclk_pos) begin
                     rxq[m_k] = serial_in;
                     m_k++;
                     m_mem = model_mem();
                     if (m_k == m_len) m_phase = 2;
                  end else if (sclk_neg) begin
                     m_sout = m_dir ? m_tx[m_k] : m_tx[W-1-m_k];
                  end
               end
            default: m_phase = 0;
         endcase
      end
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
      chk("busy", 64'(busy), 64'(m_phase == 1));
      chk("done", 64'(done), 64'(m_phase == 2));
      chk("pout", 64'(parallel_out), 64'(m_mem));
      chk("sout", 64'(serial_out), 64'(m_sout));
   endtask

   task automatic clear_inputs();
      sclk_pos = 0; sclk_neg = 0; load = 0; hold = 0; abort = 0; serial_in = 0;
   endtask

   task automatic do_load(input logic [W-1:0] pin, input logic dir, input logic [CW-1:0] flen);
      parallel_in = pin; lsb_first = dir; frame_len = flen; load = 1;
      tick();
      load = 0;
   endtask

   task automatic do_pos(input logic b, input logic h);
      serial_in = b; hold = h; sclk_pos = 1;
      tick();
      sclk_pos = 0; hold = 0;
   endtask

   task automatic do_neg();
      sclk_neg = 1;
      tick();
      sclk_neg = 0;
   endtask

   task automatic do_abort();
      abort = 1;
      tick();
      abort = 0;
   endtask

   initial begin
      logic [7:0] rxw;
      logic [7:0] seq;
      logic [7:0] partial;

      clear_inputs();
      lsb_first = 0; frame_len = '0; parallel_in = '0;
      reset_n = 0;
      model_reset();
      tick();
      tick();
      reset_n = 1;
      tick();

      // MSB first, full frame (len=0 means WIDTH)
      done_cnt = 0; rxw = 8'h3C; seq = '0;
      do_load(8'hA5, 1'b0, '0);
      seq[7] = serial_out;
      for (int i = 0; i < 8; i++) begin
         do_pos(rxw[7-i], 1'b0);
         if (i == 7) chk("t1_done_at_last", 64'(done), 64'd1);
         do_neg();
         if (i < 7) seq[6-i] = serial_out;
      end
      tick(); tick();
      chk("t1_pout", 64'(parallel_out), 64'h3C);
      chk("t1_sent", 64'(seq), 64'hA5);
      chk("t1_done_count", 64'(done_cnt), 64'd1);

      // LSB first
      rxw = 8'h0F; seq = '0;
      do_load(8'h81, 1'b1, 4'd8);
      seq[0] = serial_out;
      for (int i = 0; i < 8; i++) begin
         do_pos(rxw[i], 1'b0);
         do_neg();
         if (i < 7) seq[i+1] = serial_out;
      end
      tick();
      chk("t2_pout", 64'(parallel_out), 64'h0F);
      chk("t2_sent", 64'(seq), 64'h81);

      // Short frame, len=3
      rxw = 8'h05; seq = '0;
      do_load(8'hE0, 1'b0, 4'd3);
      seq[2] = serial_out;
      for (int i = 0; i < 3; i++) begin
         do_pos(rxw[2-i], 1'b0);
         if (i == 2) chk("t3_done_3rd", 64'(done), 64'd1);
         do_neg();
         if (i < 2) seq[1-i] = serial_out;
      end
      tick();
      chk("t3_pout", 64'(parallel_out), 64'h05);
      chk("t3_sent", 64'(seq[2:0]), 64'h7);

      // hold then abort after 4 bits
      done_cnt = 0;
      do_load(8'h5A, 1'b0, '0);
      do_pos(1'b1, 1'b0); do_neg();
      partial = parallel_out;
      do_pos(1'b0, 1'b1);
      do_pos(1'b0, 1'b1);
      chk("t4_hold_pout", 64'(parallel_out), 64'(partial));
      for (int i = 0; i < 3; i++) begin
         do_pos(1'b1, 1'b0); do_neg();
      end
      chk("t4_busy_after4", 64'(busy), 64'd1);
      partial = parallel_out;
      do_abort();
      chk("t4_abort_busy", 64'(busy), 64'd0);
      tick(); tick();
      chk("t4_abort_pout", 64'(parallel_out), 64'(partial));
      chk("t4_no_done", 64'(done_cnt), 64'd0);

      // load during SHIFT ignored; simultaneous strobes; async reset mid-frame
      do_load(8'hFF, 1'b0, '0);
      do_pos(1'b1, 1'b0);
      do_load(8'h00, 1'b1, 4'd2);
      chk("t5_load_ignored", 64'(parallel_out), 64'hFF);
      serial_in = 0; sclk_pos = 1; sclk_neg = 1;
      tick();
      clear_inputs();
      #2 reset_n = 0;
      #1;
      model_reset();
      chk("t5_rst_pout", 64'(parallel_out), 64'd0);
      chk("t5_rst_sout", 64'(serial_out), 64'd0);
      chk("t5_rst_busy", 64'(busy), 64'd0);
      chk("t5_rst_done", 64'(done), 64'd0);
      tick();
      reset_n = 1;
      tick();

      // Load in DONE ignored, load 2 cycles after final sclk_pos accepted
      do_load(8'hC3, 1'b1, 4'd2);
      do_pos(1'b0, 1'b0);
      do_pos(1'b1, 1'b0);
      do_load(8'h3C, 1'b0, '0);
      chk("t6_done_load_ign", 64'(busy), 64'd0);
      do_load(8'h3C, 1'b0, '0);
      chk("t6_next_load", 64'(busy), 64'd1);
      chk("t6_next_pout", 64'(parallel_out), 64'h3C);
      do_abort();

      // Randomised traffic against the model
      for (int n = 0; n < 3000; n++) begin
         load        = ($urandom_range(0, 99) < 8);
         lsb_first   = 1'($urandom_range(0, 1));
         frame_len   = CW'($urandom_range(0, 15));
         parallel_in = W'($urandom);
         serial_in   = 1'($urandom_range(0, 1));
         sclk_pos    = ($urandom_range(0, 3) == 0);
         sclk_neg    = ($urandom_range(0, 3) == 0);
         hold        = ($urandom_range(0, 9) == 0);
         abort       = ($urandom_range(0, 149) == 0);
         tick();
      end
      clear_inputs();
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_frame_shiftreg.md
# spi_frame_shiftreg

Parametrised serial/parallel shift engine for the SPI-attached multiplier peripheral. It loads a transmit word in parallel, then shifts it out and shifts the receive word in on strobed serial-clock edges. Frame length and bit order are selectable per frame, and it signals completion. It replaces the fixed 4-mode shift register as the datapath under the SPI slave FSM, and feeds the multiplier operand/result registers.

## Interface
- WIDTH, 8: shift register width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1): bit-counter width; derived localparam, not overridable.
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- sclk_pos  in  1  one-cycle strobe marking an SPI clock rising edge; this is the sample edge.
- sclk_neg  in  1  one-cycle strobe marking an SPI clock falling edge; this is the launch edge.
- load  in  1  starts a frame: latches parallel_in, lsb_first and frame_len.
- lsb_first  in  1  bit order. 0 means MSB first, 1 means LSB first. Sampled only on an accepted load.
- frame_len  in  CNT_W  bits per frame, 1..WIDTH. A value of 0 or greater than WIDTH is treated as WIDTH.
- hold  in  1  while high, both strobes are ignored; state and count are frozen.
- abort  in  1  synchronous frame cancel.
- parallel_in  in  WIDTH  transmit word.
- serial_in  in  1  MISO/MOSI receive bit.
- parallel_out  out  WIDTH  shift register contents, driven directly from the register.
- serial_out  out  1  registered transmit bit.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle completion pulse.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **Reset values:** state=IDLE, memory=0, count=0, serial_out=0, busy=0, done=0, latched dir=0, latched len=WIDTH.
- **IDLE:**
  - load=1: memory<=parallel_in; latch dir and len; count<=0.
  - On the same load, serial_out<=parallel_in[WIDTH-1] (MSB first) or parallel_in[0] (LSB first); state goes to SHIFT.
  - Strobes are ignored in IDLE.
- **SHIFT, sclk_pos & !hold:**
  - MSB first: memory<={memory[WIDTH-2:0], serial_in}.
  - LSB first: memory<={serial_in, memory[WIDTH-1:1]}.
  - count<=count+1. If count+1==len, go to DONE.
- **SHIFT, sclk_neg & !hold:** serial_out<=memory[WIDTH-1] (MSB first) or memory[0] (LSB first). This is the next bit to send.
- **Both strobes in the same cycle:** sclk_pos wins; sclk_neg is dropped.
- **DONE:** done=1 for exactly one cycle, busy=0, then unconditionally to IDLE. load is ignored in DONE.
- **load while SHIFT or DONE:** ignored; no state change.
- **abort=1 in any state:** next state IDLE, count<=0, no done pulse. memory and serial_out keep their values. abort has priority over load and the strobes.
- **Short frames (len<WIDTH):**
  - MSB first: received bits sit in memory[len-1:0]; untransmitted low bits sit above them.
  - LSB first: received bits sit in memory[WIDTH-1:WIDTH-len].
  - No masking is applied; the consumer selects the bits.
- **reset_n low mid-frame:** immediate return to reset values, independent of clk.

## Timing
- Load accepted at edge n: busy=1 and serial_out holds the first bit after edge n.
- Each sclk_pos at edge k: updated parallel_out is visible after edge k.
- Final sclk_pos at edge m: done=1 and busy=0 during cycle m+1; IDLE from edge m+2.
- Earliest next load is accepted at edge m+2. Back-to-back frames therefore have a 1-cycle gap.
- hold has zero latency: a strobe coinciding with hold=1 is lost, not deferred.
- Strobes are assumed already synchronised and edge-detected upstream.

## Structure
- Shared package `shiftreg_pkg` holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the bit-order constants MSB_FIRST=1'b0 and LSB_FIRST=1'b1.
  - Multiplier and SPI-slave blocks include the same package.
- One sub-module, `shiftreg_bitcounter`:
  - CNT_W counter with clear, enable and terminal-compare against len;
  - outputs `last` (count+1==len).
- FSM and datapath stay in the top.

## Test plan
- **MSB first, full frame.** WIDTH=8, load 8'hA5 with len=0; drive serial_in=8'h3C MSB first over 8 pos/neg pairs. Expect serial_out sequence 1,0,1,0,0,1,0,1; parallel_out=8'h3C; done pulses once.
- **LSB first.** lsb_first=1, load 8'h81; shift in 8'h0F LSB first. Expect serial_out 1,0,0,0,0,0,0,1; parallel_out=8'h0F.
- **Short frame.** len=3, MSB first, load 8'hE0, shift in 3'b101. Expect done after the 3rd sclk_pos; parallel_out=8'h05; 3 bits sent: 1,1,1.
- **hold and abort.**
  - hold during 2 sclk_pos: count unchanged and those bits are not captured.
  - abort after 4 bits: busy drops next cycle, no done pulse, parallel_out keeps its partial value.
- **Edge cases.**
  - load pulsed during SHIFT is ignored.
  - sclk_pos and sclk_neg in the same cycle: only the shift occurs.
  - reset_n low mid-frame: all outputs 0 immediately.
  - A new load 2 cycles after done is accepted.
